// File: rtl/uart_ctrl_pkg.sv
// Shared types and default sizing for the UART control blocks.
package uart_ctrl_pkg;

  localparam int unsigned DefaultNumReq   = 4;
  localparam int unsigned DefaultDataBits = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req scanning last+1, last+2, ... modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  always_comb begin
    int unsigned j;
    logic [N-1:0] rot;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    j      = 0;
    rot    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      j   = (32'(last) + k) % N;
      rot = req >> j;
      if (!valid && rot[0]) begin
        valid  = 1'b1;
        idx    = IW'(j);
        onehot = N'(1) << j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; runs the Transmit_Start / Tx_Busy handshake.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DefaultNumReq,
  parameter int unsigned DATA_BITS     = DefaultDataBits,
  parameter int unsigned START_TIMEOUT = 64,
  localparam int unsigned IdW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CntW         = $clog2(START_TIMEOUT + 1)
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]             Grant,
  output logic [NUM_REQ-1:0]             Done,
  output logic [DATA_BITS-1:0]           Tx_Data,
  output logic                           Transmit_Start,
  input  logic                           Tx_Busy,
  input  logic                           BIST_Busy,
  output logic [IdW-1:0]                 Active_Id,
  output logic                           Timeout_Err
);

  arb_state_t           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdW-1:0]       last_q, last_d;
  logic [IdW-1:0]       id_q, id_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 start_q, start_d;
  logic                 err_q, err_d;

  logic                 pick_valid;
  logic [IdW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IdW)
  ) u_pick (
    .req    (Req),
    .last   (last_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    id_d      = id_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    done_d    = '0;
    start_d   = start_q;
    err_d     = err_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid && !Tx_Busy && !BIST_Busy) begin
          state_d   = ARB_START;
          tx_data_d = Req_Data[32'(pick_idx) * DATA_BITS +: DATA_BITS];
          grant_d   = pick_onehot;
          id_d      = pick_idx;
          start_d   = 1'b1;
          cnt_d     = '0;
        end
      end
      ARB_START: begin
        if (Tx_Busy) begin
          start_d = 1'b0;
          state_d = ARB_BUSY;
        end else if (cnt_q == CntW'(START_TIMEOUT - 1)) begin
          // UART never acknowledged: drop the transfer without a Done pulse.
          start_d = 1'b0;
          grant_d = '0;
          err_d   = 1'b1;
          last_d  = id_q;
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_BUSY: begin
        if (!Tx_Busy) begin
          done_d  = grant_q;
          grant_d = '0;
          last_d  = id_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      last_q    <= IdW'(NUM_REQ - 1);
      id_q      <= '0;
      tx_data_q <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      id_q      <= id_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

  assign Grant          = grant_q;
  assign Done           = done_q;
  assign Tx_Data        = tx_data_q;
  assign Transmit_Start = start_q;
  assign Active_Id      = id_q;
  assign Timeout_Err    = err_q;

endmodule
